// File: rtl/fm_wm_result_collector.sv
// fm_wm_result_collector: stores one dot-product result per handshake at its (row, col) slot
// in a FEATURE_ROWS x WEIGHT_COLS buffer, filled in row-major order. Once the buffer is full,
// the block offers a registered random-access read port.
// Optional feature: define ARGMAX_EN to add a per-row argmax column, read back as rd_argmax.
module fm_wm_result_collector #(
  parameter int unsigned FEATURE_ROWS   = 6,
  parameter int unsigned WEIGHT_COLS    = 3,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  localparam int unsigned ROW_W = $clog2(FEATURE_ROWS),
  localparam int unsigned COL_W = $clog2(WEIGHT_COLS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      res_valid,
  input  logic [DOT_PROD_WIDTH-1:0] res_data,
  output logic                      res_ready,
  output logic                      done,
  input  logic                      rd_en,
  input  logic [ROW_W-1:0]          rd_row,
  input  logic [COL_W-1:0]          rd_col,
  output logic                      rd_valid,
  output logic [DOT_PROD_WIDTH-1:0] rd_data,
`ifdef ARGMAX_EN
  output logic [COL_W-1:0]          rd_argmax,
`endif
  output logic                      rd_err
);

  localparam logic [ROW_W-1:0] RowLast = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] ColLast = COL_W'(WEIGHT_COLS - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic [COL_W-1:0]          col_cnt_q, col_cnt_d;
  logic                      accept;
  logic                      last_col;
  logic                      rd_ok;

  logic [DOT_PROD_WIDTH-1:0] buf_q [FEATURE_ROWS][WEIGHT_COLS];

  logic                      rd_valid_q;
  logic                      rd_err_q;
  logic [DOT_PROD_WIDTH-1:0] rd_data_q;

  assign last_col = (col_cnt_q == ColLast);

  // A start arriving together with a read in StDone restarts collection, so the read is refused.
  assign rd_ok = rd_en && (state_q == StDone) && !start &&
                 (rd_row <= RowLast) && (rd_col <= ColLast);

  // State and write-pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  // Next state, row-major pointer advance, and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    res_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCollect;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end
      end
      StCollect: begin
        res_ready = 1'b1;
        if (res_valid) begin
          accept = 1'b1;
          if (last_col) begin
            col_cnt_d = '0;
            if (row_cnt_q == RowLast) begin
              state_d = StDone;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          state_d   = StCollect;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q[row_cnt_q][col_cnt_q] <= res_data;
    end
  end

  // Registered read port; rd_data holds its value on rejected or idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else if (rd_ok) begin
      rd_valid_q <= 1'b1;
      rd_err_q   <= 1'b0;
      rd_data_q  <= buf_q[rd_row][rd_col];
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= rd_en;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;

`ifdef ARGMAX_EN
  logic [DOT_PROD_WIDTH-1:0] row_max_q, row_max_d;
  logic [COL_W-1:0]          row_arg_q, row_arg_d;
  logic [COL_W-1:0]          argmax_q [FEATURE_ROWS];
  logic [COL_W-1:0]          rd_argmax_q;

  // Running row maximum: column 0 always loads, and a tie keeps the earlier column.
  always_comb begin
    row_max_d = row_max_q;
    row_arg_d = row_arg_q;
    if ((col_cnt_q == '0) || (res_data > row_max_q)) begin
      row_max_d = res_data;
      row_arg_d = col_cnt_q;
    end
  end

  // Argmax tracking, per-row commit on the final column, and registered readback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_max_q   <= '0;
      row_arg_q   <= '0;
      rd_argmax_q <= '0;
      for (int unsigned i = 0; i < FEATURE_ROWS; i++) begin
        argmax_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        row_max_q <= row_max_d;
        row_arg_q <= row_arg_d;
        if (last_col) begin
          argmax_q[row_cnt_q] <= row_arg_d;
        end
      end
      if (rd_ok) begin
        rd_argmax_q <= argmax_q[rd_row];
      end
    end
  end

  assign rd_argmax = rd_argmax_q;
`endif

endmodule
